// File: rtl/imem_bank_loader_pkg.sv
// imem_bank_loader_pkg: shared state encoding and default sizes for the
// instruction-memory boot/reload sequencer.
`default_nettype none

package imem_bank_loader_pkg;

  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 16;
  localparam int IMG_DEPTH = 2 ** AW_DEF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_RUN   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/imem_bank_loader.sv
// imem_bank_loader: copies a selected code bank into instruction RAM one word
// per clock, holding the CPU and clearing its PC once the image is in place.
`default_nettype none

module imem_bank_loader
  import imem_bank_loader_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int BW       = 2,
  parameter bit AUTOLOAD = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic [BW-1:0] bank_sel,
  output logic [BW-1:0] img_bank,
  output logic [AW-1:0] img_addr,
  input  logic [DW-1:0] img_data,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [DW-1:0] imem_wdata,
  output logic          cpu_hold,
  output logic          cpu_pc_clr,
  output logic          busy,
  output logic          load_done,
  output logic [DW-1:0] checksum
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [DW-1:0] chk_acc_q, chk_acc_d;
  logic [DW-1:0] checksum_q, checksum_d;
  logic          hold_q, hold_d;
  logic          pc_clr_q, pc_clr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    chk_acc_d  = chk_acc_q;
    checksum_d = checksum_q;
    case (state_q)
      S_IDLE: begin
        if (AUTOLOAD != 1'b0) begin
          bank_d  = '0;
          state_d = S_LOAD;
        end else if (load_req) begin
          bank_d  = bank_sel;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        chk_acc_d = chk_acc_q ^ img_data;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == {AW{1'b1}}) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        checksum_d = chk_acc_q;
        chk_acc_d  = '0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (load_req) begin
          bank_d  = bank_sel;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered, so decode them from the next state.
    hold_d   = (state_d != S_RUN);
    busy_d   = (state_d == S_LOAD) || (state_d == S_FLUSH);
    pc_clr_d = (state_d == S_FLUSH);
    done_d   = (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bank_q     <= '0;
      chk_acc_q  <= '0;
      checksum_q <= '0;
      hold_q     <= 1'b1;
      pc_clr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      chk_acc_q  <= chk_acc_d;
      checksum_q <= checksum_d;
      hold_q     <= hold_d;
      pc_clr_q   <= pc_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Write port is decoded straight from state so a reset drops it at once.
  assign imem_we    = (state_q == S_LOAD);
  assign imem_waddr = cnt_q;
  assign imem_wdata = img_data;
  assign img_bank   = bank_q;
  assign img_addr   = cnt_q;

  assign cpu_hold   = hold_q;
  assign cpu_pc_clr = pc_clr_q;
  assign busy       = busy_q;
  assign load_done  = done_q;
  assign checksum   = checksum_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_bank_loader.sv
// tb_imem_bank_loader: scoreboard bench for the instruction-memory loader,
// one instance with autoload and one without.
`default_nettype none

module tb_imem_bank_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, load_req_a, imem_we_a, hold_a, pcclr_a, busy_a, done_a;
  logic [1:0]  bank_sel_a, img_bank_a;
  logic [3:0]  img_addr_a, waddr_a;
  logic [15:0] img_data_a, wdata_a, checksum_a;

  logic        rst_n_b, load_req_b, imem_we_b, hold_b, pcclr_b, busy_b, done_b;
  logic [1:0]  bank_sel_b, img_bank_b;
  logic [3:0]  img_addr_b, waddr_b;
  logic [15:0] img_data_b, wdata_b, checksum_b;

  int tests = 0;
  int fails = 0;
  int writes_a = 0, dones_a = 0, writes_b = 0, dones_b = 0;
  logic [21:0] q_a[$];
  logic [21:0] q_b[$];
  logic [21:0] e_a, e_b;

  function automatic logic [15:0] img_word(input logic [1:0] b, input logic [3:0] a);
    case (b)
      2'd0:    img_word = 16'h1000 + {12'h000, a};
      2'd1:    img_word = (a == 4'd3) ? 16'h0001 : 16'hA5A5;
      2'd2:    img_word = 16'h2000 ^ ({12'h000, a} * 16'h0123);
      default: img_word = {a, 4'hC, ~a, 4'h3};
    endcase
  endfunction

  assign img_data_a = img_word(img_bank_a, img_addr_a);
  assign img_data_b = img_word(img_bank_b, img_addr_b);

  imem_bank_loader #(.AW(4), .DW(16), .BW(2), .AUTOLOAD(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .load_req(load_req_a), .bank_sel(bank_sel_a),
    .img_bank(img_bank_a), .img_addr(img_addr_a), .img_data(img_data_a),
    .imem_we(imem_we_a), .imem_waddr(waddr_a), .imem_wdata(wdata_a),
    .cpu_hold(hold_a), .cpu_pc_clr(pcclr_a), .busy(busy_a),
    .load_done(done_a), .checksum(checksum_a)
  );

  imem_bank_loader #(.AW(4), .DW(16), .BW(2), .AUTOLOAD(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .load_req(load_req_b), .bank_sel(bank_sel_b),
    .img_bank(img_bank_b), .img_addr(img_addr_b), .img_data(img_data_b),
    .imem_we(imem_we_b), .imem_waddr(waddr_b), .imem_wdata(wdata_b),
    .cpu_hold(hold_b), .cpu_pc_clr(pcclr_b), .busy(busy_b),
    .load_done(done_b), .checksum(checksum_b)
  );

  // Write monitors: every RAM write must match the next expected {bank,addr,data}.
  always @(negedge clk) begin
    if (rst_n_a === 1'b1) begin
      if (imem_we_a === 1'b1) begin
        tests++;
        writes_a++;
        if (q_a.size() == 0) begin
          fails++;
          $display("FAIL a_write_unexpected got bank=%0d addr=%0d data=%h, required none",
                   img_bank_a, waddr_a, wdata_a);
        end else begin
          e_a = q_a.pop_front();
          if ({img_bank_a, waddr_a, wdata_a} !== e_a || hold_a !== 1'b1 || busy_a !== 1'b1) begin
            fails++;
            $display("FAIL a_write got bank=%0d addr=%0d data=%h hold=%b busy=%b, required bank=%0d addr=%0d data=%h hold=1 busy=1",
                     img_bank_a, waddr_a, wdata_a, hold_a, busy_a, e_a[21:20], e_a[19:16], e_a[15:0]);
          end
        end
      end
      if (done_a === 1'b1) dones_a++;
      if (pcclr_a !== done_a) begin
        tests++;
        fails++;
        $display("FAIL a_pcclr_vs_done got pc_clr=%b, required %b", pcclr_a, done_a);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n_b === 1'b1) begin
      if (imem_we_b === 1'b1) begin
        tests++;
        writes_b++;
        if (q_b.size() == 0) begin
          fails++;
          $display("FAIL b_write_unexpected got bank=%0d addr=%0d data=%h, required none",
                   img_bank_b, waddr_b, wdata_b);
        end else begin
          e_b = q_b.pop_front();
          if ({img_bank_b, waddr_b, wdata_b} !== e_b) begin
            fails++;
            $display("FAIL b_write got bank=%0d addr=%0d data=%h, required bank=%0d addr=%0d data=%h",
                     img_bank_b, waddr_b, wdata_b, e_b[21:20], e_b[19:16], e_b[15:0]);
          end
        end
      end
      if (done_b === 1'b1) dones_b++;
    end
  end

  task automatic push_load(input bit to_b, input logic [1:0] bank, output logic [15:0] ck);
    logic [3:0]  a;
    logic [15:0] w;
    ck = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      a  = 4'(i);
      w  = img_word(bank, a);
      ck = ck ^ w;
      if (to_b) q_b.push_back({bank, a, w});
      else      q_a.push_back({bank, a, w});
    end
  endtask

  task automatic start_load_a(input logic [1:0] bank, output logic [15:0] ck);
    @(negedge clk);
    push_load(1'b0, bank, ck);
    load_req_a = 1'b1;
    bank_sel_a = bank;
    @(posedge clk);
    #1 load_req_a = 1'b0;
  endtask

  task automatic wait_run_a(output int cyc);
    cyc = 0;
    while (hold_a !== 1'b0 && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    tests++;
    if (hold_a !== 1'b0) begin
      fails++;
      $display("FAIL a_wait_run got cpu_hold=%b after %0d cycles, required 0", hold_a, cyc);
    end
  endtask

  task automatic check_load_end_a(input string nm, input int w0, input int d0, input logic [15:0] ck);
    tests++;
    if (writes_a - w0 != 16 || dones_a - d0 != 1 || q_a.size() != 0 || checksum_a !== ck) begin
      fails++;
      $display("FAIL %s got writes=%0d dones=%0d left=%0d checksum=%h, required 16 1 0 %h",
               nm, writes_a - w0, dones_a - d0, q_a.size(), checksum_a, ck);
    end
  endtask

  task automatic test_reset;
    rst_n_a = 1'b0; load_req_a = 1'b0; bank_sel_a = 2'd0;
    rst_n_b = 1'b0; load_req_b = 1'b0; bank_sel_b = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({hold_a, imem_we_a, busy_a, done_a, pcclr_a} !== 5'b10000 || checksum_a !== 16'h0000) begin
      fails++;
      $display("FAIL reset got hold/we/busy/done/pcclr=%b checksum=%h, required 10000 0000",
               {hold_a, imem_we_a, busy_a, done_a, pcclr_a}, checksum_a);
    end
  endtask

  task automatic test_autoload;
    logic [15:0] ck;
    push_load(1'b0, 2'd0, ck);
    @(negedge clk) rst_n_a = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk);
      #1;
      if (c == 1 || c == 16) begin
        tests++;
        if (imem_we_a !== 1'b1) begin
          fails++;
          $display("FAIL autoload_we cycle %0d got %b, required 1", c, imem_we_a);
        end
      end
      if (c == 17) begin
        tests++;
        if ({imem_we_a, done_a, pcclr_a, busy_a, hold_a} !== 5'b01111) begin
          fails++;
          $display("FAIL autoload_flush got we/done/pcclr/busy/hold=%b, required 01111",
                   {imem_we_a, done_a, pcclr_a, busy_a, hold_a});
        end
      end
      if (c == 18) begin
        tests++;
        if ({hold_a, busy_a, done_a} !== 3'b000) begin
          fails++;
          $display("FAIL autoload_run got hold/busy/done=%b, required 000", {hold_a, busy_a, done_a});
        end
      end
    end
    check_load_end_a("autoload_end", 0, 0, ck);
  endtask

  task automatic test_bank1;
    logic [15:0] ck;
    int cyc, w0, d0;
    w0 = writes_a; d0 = dones_a;
    start_load_a(2'd1, ck);
    wait_run_a(cyc);
    tests++;
    if (cyc != 17) begin
      fails++;
      $display("FAIL bank1_latency got %0d cycles after accept edge, required 17", cyc);
    end
    check_load_end_a("bank1_end", w0, d0, ck);
  endtask

  task automatic test_bank_change;
    logic [15:0] ck;
    int cyc, w0, d0;
    w0 = writes_a; d0 = dones_a;
    start_load_a(2'd1, ck);
    repeat (4) @(posedge clk);
    #1 bank_sel_a = 2'd2;
    wait_run_a(cyc);
    check_load_end_a("bank_change_end", w0, d0, ck);
  endtask

  task automatic test_req_ignored;
    logic [15:0] ck;
    int w0, d0;
    w0 = writes_a; d0 = dones_a;
    start_load_a(2'd2, ck);
    repeat (7) @(posedge clk);
    #1 load_req_a = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    tests++;
    if ({done_a, busy_a, hold_a} !== 3'b111) begin
      fails++;
      $display("FAIL ignored_flush got done/busy/hold=%b, required 111", {done_a, busy_a, hold_a});
    end
    @(posedge clk);
    #1 load_req_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (hold_a !== 1'b0 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL ignored_run got hold=%b busy=%b, required 0 0", hold_a, busy_a);
    end
    check_load_end_a("ignored_end", w0, d0, ck);
  endtask

  task automatic test_back_to_back;
    logic [15:0] ck0, ck1;
    int d0, first, second;
    d0 = dones_a; first = -1; second = -1;
    @(negedge clk);
    push_load(1'b0, 2'd3, ck0);
    push_load(1'b0, 2'd0, ck1);
    load_req_a = 1'b1;
    bank_sel_a = 2'd3;
    for (int c = 1; c <= 60 && second < 0; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) bank_sel_a = 2'd0;
      if (done_a === 1'b1) begin
        if (first < 0) first = c;
        else begin
          second = c;
          load_req_a = 1'b0;
        end
      end
    end
    load_req_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (second - first != 18 || dones_a - d0 != 2 || q_a.size() != 0 || checksum_a !== ck1) begin
      fails++;
      $display("FAIL back_to_back got interval=%0d dones=%0d left=%0d checksum=%h, required 18 2 0 %h",
               second - first, dones_a - d0, q_a.size(), checksum_a, ck1);
    end
  endtask

  task automatic test_reset_midload;
    logic [15:0] ck;
    int cyc, w0, d0;
    start_load_a(2'd2, ck);
    repeat (6) @(posedge clk);
    #2 rst_n_a = 1'b0;
    #1;
    tests++;
    if ({imem_we_a, hold_a, busy_a} !== 3'b010 || checksum_a !== 16'h0000) begin
      fails++;
      $display("FAIL midload_reset got we/hold/busy=%b checksum=%h, required 010 0000",
               {imem_we_a, hold_a, busy_a}, checksum_a);
    end
    q_a.delete();
    push_load(1'b0, 2'd0, ck);
    w0 = writes_a; d0 = dones_a;
    @(negedge clk) rst_n_a = 1'b1;
    wait_run_a(cyc);
    tests++;
    if (cyc != 18) begin
      fails++;
      $display("FAIL midload_reload_latency got %0d, required 18", cyc);
    end
    check_load_end_a("midload_reload_end", w0, d0, ck);
  endtask

  task automatic test_no_autoload;
    logic [15:0] ck;
    int cyc, bad;
    bad = 0;
    @(negedge clk) rst_n_b = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if ({hold_b, imem_we_b, busy_b} !== 3'b100) bad++;
    end
    tests++;
    if (bad != 0 || writes_b != 0) begin
      fails++;
      $display("FAIL no_autoload_idle got %0d bad cycles %0d writes, required 0 0", bad, writes_b);
    end
    @(negedge clk);
    push_load(1'b1, 2'd3, ck);
    load_req_b = 1'b1;
    bank_sel_b = 2'd3;
    @(posedge clk);
    #1 load_req_b = 1'b0;
    cyc = 0;
    while (hold_b !== 1'b0 && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    tests++;
    if (cyc != 17 || writes_b != 16 || dones_b != 1 || q_b.size() != 0 || checksum_b !== ck) begin
      fails++;
      $display("FAIL no_autoload_load got cyc=%0d writes=%0d dones=%0d left=%0d checksum=%h, required 17 16 1 0 %h",
               cyc, writes_b, dones_b, q_b.size(), checksum_b, ck);
    end
  endtask

  initial begin
    test_reset();
    test_autoload();
    test_bank1();
    test_bank_change();
    test_req_ignored();
    test_back_to_back();
    test_reset_midload();
    test_no_autoload();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
